board_key_conditioner: RTL and testbench
========================================

BOARD_KEY_CONDITIONER -- requirements
Module: board_key_conditioner

Interface
REQ-001 SHALL have parameter w_key, default 2: number of board keys.
REQ-002 SHALL have parameter key_active_low, default 1: 1 means a raw key reads 0 when pressed.
REQ-003 SHALL have parameter reverse_key, default 1: 1 means output bit i maps from raw bit w_key-1-i.
REQ-004 SHALL have parameter tick_cycles, default 27000: clk cycles per debounce tick (1 ms at 27 MHz).
REQ-005 SHALL have parameter debounce_ticks, default 10: ticks of stable input required to accept a change.
REQ-006 SHALL have parameter por_cycles, default 1024: power-up reset length in clk cycles.
REQ-007 SHALL have parameter reset_mode, default 0: 0 is POR only; 1 is POR or any key; 2 is POR or all keys held hold_ticks.
REQ-008 SHALL have parameter hold_ticks, default 2000: all-keys hold time for mode 2.
REQ-009 SHALL have port clk, input, 1 bit: the single clock.
REQ-010 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on clk rising edge.
REQ-011 SHALL have port raw_key, input, w_key bits: asynchronous board buttons.
REQ-012 SHALL have port key, output, w_key bits: debounced level, active-high, order-corrected.
REQ-013 SHALL have port key_pressed, output, w_key bits: one-cycle pulse on a 0->1 transition of key.
REQ-014 SHALL have port key_released, output, w_key bits: one-cycle pulse on a 1->0 transition of key.
REQ-015 SHALL have port any_key, output, 1 bit: OR of key.
REQ-016 SHALL have port rst, output, 1 bit: active-high, registered system reset for downstream logic.

Function
REQ-017 SHALL pass each raw_key bit through a 2-flop synchronizer, then invert it if key_active_low, then apply reverse_key mapping; the result is "sync".
REQ-018 SHALL use one shared tick counter that pulses for 1 cycle every tick_cycles cycles (count 0..tick_cycles-1, wraps).
REQ-019 SHALL give each key its own counter of width clog2(debounce_ticks+1), cleared in any cycle where sync[i]==key[i].
REQ-020 SHALL, on a tick with sync[i]!=key[i], set key[i]<=sync[i] and clear the counter if the counter==debounce_ticks-1; otherwise it increments the counter.
REQ-021 SHALL hold key[i] when any mismatch gap returns to equality (a glitch shorter than the window); the counter restarts from 0.
REQ-022 SHALL assert key_pressed[i] / key_released[i] in the same cycle key[i] changes, for exactly 1 cycle; the two SHALL never both be 1 for one bit.
REQ-023 SHALL debounce keys independently; simultaneous changes on several keys SHALL produce simultaneous pulses.
REQ-024 SHALL implement a reset FSM with states POR, RUN, ARM, KEYRST.
REQ-025 POR: rst=1; a cycle counter runs 0..por_cycles-1; at terminal count go to RUN.
REQ-026 RUN: rst=0; mode 1 goes to KEYRST when any_key=1; mode 2 goes to ARM when key==all ones; mode 0 stays in RUN.
REQ-027 ARM (mode 2): rst=0; count ticks while key==all ones; return to RUN if any key releases; go to KEYRST when the count reaches hold_ticks.
REQ-028 KEYRST: rst=1; go to POR (full por_cycles restart) when any_key=0 (mode 1) or key!=all ones (mode 2).
REQ-029 SHALL register rst; its latency from state entry is 1 cycle.
REQ-030 SHALL keep the debouncer running in every FSM state; rst SHALL NOT clear key.

Reset
REQ-031 SHALL, while rst_n=0 at a clk edge: clear synchronizers, key, counters and pulses to 0; set any_key=0 and rst=1; set FSM=POR with counter 0.
REQ-032 SHALL treat rst_n deassertion mid-operation (any state, any counter value) identically to power-up: a fresh POR of por_cycles cycles after rst_n rises.
REQ-033 SHALL require no reset on outputs other than those listed; no asynchronous reset paths.

Verification (tick_cycles=4, debounce_ticks=3, por_cycles=8, hold_ticks=5, w_key=2, active-low, reverse=1)
REQ-034 rst_n low 2 cycles then high -> rst=1 for 8 cycles after release, then 0; key=00.
REQ-035 raw_key[0] to 0 held 20 cycles -> key[1] rises 10-14 cycles after the change; key_pressed[1] is 1 for one cycle; key[0] stays 0.
REQ-036 raw_key[0] low 6 cycles then back high (bounce) -> key remains 00; no pulses.
REQ-037 mode 2, both raw keys low 40 cycles -> after debounce, ARM; rst rises after 5 ticks; on release rst holds 8 more cycles then falls.
REQ-038 mode 1, key pressed in RUN -> rst=1 while held; rst_n pulsed low during KEYRST -> outputs cleared and POR restarts from 0.

Source files
------------

// File: rtl/board_key_conditioner.sv
// board_key_conditioner: synchronise, debounce and edge-detect board keys, and generate a power-up/key-driven system reset
module board_key_conditioner #(
    parameter int w_key          = 2,
    parameter int key_active_low = 1,
    parameter int reverse_key    = 1,
    parameter int tick_cycles    = 27000,
    parameter int debounce_ticks = 10,
    parameter int por_cycles     = 1024,
    parameter int reset_mode     = 0,
    parameter int hold_ticks     = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [w_key-1:0] raw_key,
    output logic [w_key-1:0] key,
    output logic [w_key-1:0] key_pressed,
    output logic [w_key-1:0] key_released,
    output logic             any_key,
    output logic             rst
);
    localparam int W_TICK = $clog2(tick_cycles + 1);
    localparam int W_DB   = $clog2(debounce_ticks + 1);
    localparam int W_POR  = $clog2(por_cycles + 1);
    localparam int W_HOLD = $clog2(hold_ticks + 1);
    localparam logic [W_TICK-1:0] TICK_LAST = W_TICK'(tick_cycles - 1);
    localparam logic [W_DB-1:0]   DB_LAST   = W_DB'(debounce_ticks - 1);
    localparam logic [W_POR-1:0]  POR_LAST  = W_POR'(por_cycles - 1);
    localparam logic [W_HOLD-1:0] HOLD_LAST = W_HOLD'(hold_ticks - 1);

    typedef enum logic [1:0] {POR, RUN, ARM, KEYRST} state_t;

    logic [w_key-1:0]  r_meta, r_sync, w_sync;
    logic [w_key-1:0]  r_key, r_pressed, r_released;
    logic [W_DB-1:0]   r_db_cnt [w_key];
    logic [W_TICK-1:0] r_tick_cnt;
    logic              w_tick;
    logic [W_POR-1:0]  r_por_cnt;
    logic [W_HOLD-1:0] r_hold_cnt;
    state_t            r_state, w_next;
    logic              r_rst;
    logic              w_all;

    assign w_tick       = r_tick_cnt == TICK_LAST;
    assign w_all        = &r_key;
    assign key          = r_key;
    assign key_pressed  = r_pressed;
    assign key_released = r_released;
    assign any_key      = |r_key;
    assign rst          = r_rst;

    // two-flop synchroniser on the raw board buttons
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= raw_key;
            r_sync <= r_meta;
        end
    end

    // polarity correction and optional bit-order reversal
    always_comb begin
        w_sync = '0;
        for (int i = 0; i < w_key; i++)
            w_sync[i] = (reverse_key != 0 ? r_sync[w_key-1-i] : r_sync[i]) ^ (key_active_low != 0);
    end

    // shared free-running debounce tick
    always_ff @(posedge clk) begin
        if (!rst_n || w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // per-key debounce: accept a change only after debounce_ticks ticks of continuous mismatch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key      <= '0;
            r_pressed  <= '0;
            r_released <= '0;
            for (int i = 0; i < w_key; i++)
                r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < w_key; i++) begin
                r_pressed[i]  <= 1'b0;
                r_released[i] <= 1'b0;
                if (w_sync[i] == r_key[i])
                    r_db_cnt[i] <= '0;
                else if (w_tick) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_key[i]      <= w_sync[i];
                        r_pressed[i]  <= w_sync[i];
                        r_released[i] <= ~w_sync[i];
                        r_db_cnt[i]   <= '0;
                    end else
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // reset FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            POR:     if (r_por_cnt == POR_LAST) w_next = RUN;
            RUN:     if (reset_mode == 1 && any_key) w_next = KEYRST;
                     else if (reset_mode == 2 && w_all) w_next = ARM;
            ARM:     if (!w_all) w_next = RUN;
                     else if (w_tick && r_hold_cnt == HOLD_LAST) w_next = KEYRST;
            KEYRST:  if (reset_mode == 2 ? !w_all : !any_key) w_next = POR;
            default: w_next = POR;
        endcase
    end

    // FSM state, its counters, and the registered system reset (one cycle behind the state)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= POR;
            r_por_cnt  <= '0;
            r_hold_cnt <= '0;
            r_rst      <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_por_cnt  <= (r_state == POR && w_next == POR) ? r_por_cnt + 1'b1 : '0;
            r_hold_cnt <= (r_state == ARM && w_next == ARM) ? r_hold_cnt + W_HOLD'(w_tick) : '0;
            r_rst      <= r_state == POR || r_state == KEYRST;
        end
    end
endmodule

// File: tb/tb_board_key_conditioner.sv
// tb_board_key_conditioner: scoreboard bench for the key conditioner in all three reset modes
module tb_board_key_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw_key = 2'b11;
    logic [1:0] m0_key, m0_pr, m0_rl, m1_key, m1_pr, m1_rl, m2_key, m2_pr, m2_rl;
    logic       m0_any, m0_rst, m1_any, m1_rst, m2_any, m2_rst;
    int tests = 0;
    int failed = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0] key;
        logic [1:0] pr;
        logic [1:0] rl;
        int         lo;
        int         hi;
    } ev_t;
    ev_t q[$];
    ev_t mon_e;

    board_key_conditioner #(.w_key(2), .key_active_low(1), .reverse_key(1), .tick_cycles(4), .debounce_ticks(3),
        .por_cycles(8), .reset_mode(0), .hold_ticks(5)) m0 (.clk(clk), .rst_n(rst_n), .raw_key(raw_key),
        .key(m0_key), .key_pressed(m0_pr), .key_released(m0_rl), .any_key(m0_any), .rst(m0_rst));
    board_key_conditioner #(.w_key(2), .key_active_low(1), .reverse_key(1), .tick_cycles(4), .debounce_ticks(3),
        .por_cycles(8), .reset_mode(1), .hold_ticks(5)) m1 (.clk(clk), .rst_n(rst_n), .raw_key(raw_key),
        .key(m1_key), .key_pressed(m1_pr), .key_released(m1_rl), .any_key(m1_any), .rst(m1_rst));
    board_key_conditioner #(.w_key(2), .key_active_low(1), .reverse_key(1), .tick_cycles(4), .debounce_ticks(3),
        .por_cycles(8), .reset_mode(2), .hold_ticks(5)) m2 (.clk(clk), .rst_n(rst_n), .raw_key(raw_key),
        .key(m2_key), .key_pressed(m2_pr), .key_released(m2_rl), .any_key(m2_any), .rst(m2_rst));

    // clock
    always #5 clk = ~clk;

    // rising-edge counter used as the timestamp for expected events
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor: every edge pulse must match the oldest expected event
    always @(negedge clk) begin
        if ((m0_pr | m0_rl) != 2'b00) begin
            tests++;
            if (q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_event cyc=%0d key=%b pressed=%b released=%b", cyc, m0_key, m0_pr, m0_rl);
            end else begin
                mon_e = q.pop_front();
                if (m0_key !== mon_e.key || m0_pr !== mon_e.pr || m0_rl !== mon_e.rl || cyc < mon_e.lo || cyc > mon_e.hi) begin
                    failed++;
                    $display("FAIL event got key=%b pr=%b rl=%b cyc=%0d exp key=%b pr=%b rl=%b cyc=%0d..%0d",
                             m0_key, m0_pr, m0_rl, cyc, mon_e.key, mon_e.pr, mon_e.rl, mon_e.lo, mon_e.hi);
                end
            end
            tests++;
            if ((m0_pr & m0_rl) !== 2'b00) begin
                failed++;
                $display("FAIL pulse_overlap got pr=%b rl=%b exp disjoint", m0_pr, m0_rl);
            end
        end
    end

    task automatic push_ev(input logic [1:0] k, input logic [1:0] pr, input logic [1:0] rl);
        q.push_back('{k, pr, rl, cyc + 10, cyc + 14});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n = 0;
        raw_key = 2'b11;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (m0_key !== 2'b00) begin failed++; $display("FAIL rst_key got=%b exp=00", m0_key); end
        tests++; if (m0_rst !== 1'b1) begin failed++; $display("FAIL rst_rst got=%b exp=1", m0_rst); end
        tests++; if (m0_any !== 1'b0) begin failed++; $display("FAIL rst_any got=%b exp=0", m0_any); end
        tests++; if ((m0_pr | m0_rl) !== 2'b00) begin failed++; $display("FAIL rst_pulses got=%b/%b exp=00/00", m0_pr, m0_rl); end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m0_rst !== 1'b1) break;
            n++;
        end
        tests++; if (n != 8) begin failed++; $display("FAIL por_len got=%0d exp=8", n); end
        tests++; if (m1_rst !== 1'b0 || m2_rst !== 1'b0) begin failed++; $display("FAIL por_end_m12 got=%b%b exp=00", m1_rst, m2_rst); end
        tests++; if (m0_key !== 2'b00) begin failed++; $display("FAIL por_key got=%b exp=00", m0_key); end
    endtask

    task automatic test_press();
        raw_key = 2'b10;
        push_ev(2'b10, 2'b10, 2'b00);
        repeat (20) @(negedge clk);
        tests++; if (m0_key !== 2'b10) begin failed++; $display("FAIL press_key got=%b exp=10", m0_key); end
        tests++; if (m0_any !== 1'b1) begin failed++; $display("FAIL press_any got=%b exp=1", m0_any); end
        tests++; if (m0_rst !== 1'b0) begin failed++; $display("FAIL mode0_rst got=%b exp=0", m0_rst); end
        raw_key = 2'b11;
        push_ev(2'b00, 2'b00, 2'b10);
        repeat (20) @(negedge clk);
        tests++; if (m0_key !== 2'b00) begin failed++; $display("FAIL release_key got=%b exp=00", m0_key); end
        tests++; if (q.size() != 0) begin failed++; $display("FAIL press_pending got=%0d exp=0", q.size()); end
        q.delete();
    endtask

    task automatic test_bounce();
        raw_key = 2'b10;
        repeat (6) @(negedge clk);
        raw_key = 2'b11;
        repeat (20) @(negedge clk);
        tests++; if (m0_key !== 2'b00) begin failed++; $display("FAIL bounce_key got=%b exp=00", m0_key); end
        tests++; if (q.size() != 0) begin failed++; $display("FAIL bounce_pending got=%0d exp=0", q.size()); end
        q.delete();
    endtask

    task automatic test_back_to_back();
        raw_key = 2'b00;
        push_ev(2'b11, 2'b11, 2'b00);
        repeat (20) @(negedge clk);
        tests++; if (m0_key !== 2'b11) begin failed++; $display("FAIL both_key got=%b exp=11", m0_key); end
        raw_key = 2'b11;
        push_ev(2'b00, 2'b00, 2'b11);
        repeat (20) @(negedge clk);
        raw_key = 2'b01;
        push_ev(2'b01, 2'b01, 2'b00);
        repeat (20) @(negedge clk);
        tests++; if (m0_key !== 2'b01) begin failed++; $display("FAIL rev_key got=%b exp=01", m0_key); end
        raw_key = 2'b11;
        push_ev(2'b00, 2'b00, 2'b01);
        repeat (20) @(negedge clk);
        tests++; if (q.size() != 0) begin failed++; $display("FAIL b2b_pending got=%0d exp=0", q.size()); end
        q.delete();
    endtask

    task automatic test_mode2();
        int t_key = -1;
        int t_rst = -1;
        int t_kf = -1;
        int t_rf = -1;
        do_reset();
        repeat (12) @(negedge clk);
        tests++; if (m2_rst !== 1'b0) begin failed++; $display("FAIL m2_run_rst got=%b exp=0", m2_rst); end
        raw_key = 2'b00;
        push_ev(2'b11, 2'b11, 2'b00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (t_key < 0 && m2_key == 2'b11) t_key = cyc;
            if (t_rst < 0 && m2_rst == 1'b1) t_rst = cyc;
        end
        raw_key = 2'b11;
        push_ev(2'b00, 2'b00, 2'b11);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (t_kf < 0 && m2_key != 2'b11) t_kf = cyc;
            if (t_rf < 0 && t_rst >= 0 && m2_rst == 1'b0) t_rf = cyc;
        end
        tests++;
        if (t_key < 0 || t_rst < 0 || t_rst - t_key < 19 || t_rst - t_key > 23) begin
            failed++; $display("FAIL m2_hold_delay got=%0d exp=19..23", t_rst - t_key);
        end
        tests++;
        if (t_kf < 0 || t_rf < 0 || t_rf - t_kf < 9 || t_rf - t_kf > 11) begin
            failed++; $display("FAIL m2_por_after_release got=%0d exp=9..11", t_rf - t_kf);
        end
        tests++; if (q.size() != 0) begin failed++; $display("FAIL m2_pending got=%0d exp=0", q.size()); end
        q.delete();
    endtask

    task automatic test_mode1();
        int t = -1;
        int n = 0;
        do_reset();
        repeat (12) @(negedge clk);
        tests++; if (m1_rst !== 1'b0) begin failed++; $display("FAIL m1_run_rst got=%b exp=0", m1_rst); end
        raw_key = 2'b10;
        push_ev(2'b10, 2'b10, 2'b00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m1_rst === 1'b1) begin t = i; break; end
        end
        tests++; if (t < 0) begin failed++; $display("FAIL m1_keyrst_timeout got=none exp=rst rise"); end
        repeat (10) @(negedge clk);
        tests++; if (m1_rst !== 1'b1) begin failed++; $display("FAIL m1_keyrst_hold got=%b exp=1", m1_rst); end
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (m1_key !== 2'b00 || m1_any !== 1'b0) begin failed++; $display("FAIL m1_clear got=%b/%b exp=00/0", m1_key, m1_any); end
        tests++; if (m1_rst !== 1'b1 || (m1_pr | m1_rl) !== 2'b00) begin failed++; $display("FAIL m1_clear_rst got=%b %b/%b exp=1 00/00", m1_rst, m1_pr, m1_rl); end
        rst_n = 1'b1;
        push_ev(2'b10, 2'b10, 2'b00);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m1_rst !== 1'b1) break;
            n++;
        end
        tests++; if (n != 8) begin failed++; $display("FAIL m1_repor_len got=%0d exp=8", n); end
        repeat (10) @(negedge clk);
        tests++; if (m1_key !== 2'b10 || m1_rst !== 1'b1) begin failed++; $display("FAIL m1_rearm got=%b/%b exp=10/1", m1_key, m1_rst); end
        raw_key = 2'b11;
        push_ev(2'b00, 2'b00, 2'b10);
        repeat (25) @(negedge clk);
        tests++; if (q.size() != 0) begin failed++; $display("FAIL m1_pending got=%0d exp=0", q.size()); end
        q.delete();
    endtask

    // test sequence
    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_back_to_back();
        test_mode2();
        test_mode1();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
